// File: rtl/gato_board.sv
// Board keeper and referee for 3x3 tic-tac-toe. It validates and writes moves,
// then scans the eight winning lines one per clock when asked and raises
// sticky result flags for the upstream game FSM.
module gato_board (
  input  logic        clk,
  input  logic        reset,
  input  logic        turno_p1,
  input  logic        turno_p2,
  input  logic        verifica_status,
  input  logic        sel_valid,
  input  logic [3:0]  sel_cell,
  output logic        p1_mm,
  output logic        p2_mm,
  output logic        invalid_move,
  output logic [17:0] board,
  output logic        check_done,
  output logic        p1_win,
  output logic        p1_loss,
  output logic        p1_tie,
  output logic        p2_win,
  output logic        p2_loss,
  output logic        p2_tie
);

  typedef enum logic [1:0] {IDLE, SCAN, OVER} state_t;

  // Line table, line 0 in the low bits; each entry holds three 4-bit cell indices.
  localparam logic [95:0] LINE_TAB = {12'h246, 12'h048, 12'h258, 12'h147,
                                      12'h036, 12'h678, 12'h345, 12'h012};

  state_t      state_reg, state_next;
  logic [3:0]  line_cnt_reg, line_cnt_next;
  logic        p1_found_reg, p1_found_next;
  logic        p2_found_reg, p2_found_next;
  logic [17:0] board_reg, board_next;
  logic        p1_mm_reg, p1_mm_next;
  logic        p2_mm_reg, p2_mm_next;
  logic        invalid_reg, invalid_next;
  logic        done_reg, done_next;
  // {p1_win, p1_loss, p1_tie, p2_win, p2_loss, p2_tie}
  logic [5:0]  result_reg, result_next;

  logic [15:0] cell_occ;
  logic [7:0]  line_p1;
  logic [7:0]  line_p2;
  logic        move_ok;

  // Per-cell occupancy; indices 9..15 read as occupied so they are always rejected.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_occ
      assign cell_occ[gi] = |board_reg[2*gi +: 2];
    end
  endgenerate
  assign cell_occ[15:9] = '1;

  // Per-line "all three cells owned by P1 / P2" detectors.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      localparam int CA = int'(LINE_TAB[12*gi+8 +: 4]);
      localparam int CB = int'(LINE_TAB[12*gi+4 +: 4]);
      localparam int CC = int'(LINE_TAB[12*gi   +: 4]);
      assign line_p1[gi] = (board_reg[2*CA +: 2] == 2'b01) &&
                           (board_reg[2*CB +: 2] == 2'b01) &&
                           (board_reg[2*CC +: 2] == 2'b01);
      assign line_p2[gi] = (board_reg[2*CA +: 2] == 2'b10) &&
                           (board_reg[2*CB +: 2] == 2'b10) &&
                           (board_reg[2*CC +: 2] == 2'b10);
    end
  endgenerate

  assign move_ok = (turno_p1 ^ turno_p2) && !cell_occ[sel_cell];

  // Next-state logic: move handling, sequential line scan and verdict.
  always_comb begin
    state_next    = state_reg;
    line_cnt_next = line_cnt_reg;
    p1_found_next = p1_found_reg;
    p2_found_next = p2_found_reg;
    board_next    = board_reg;
    result_next   = result_reg;
    p1_mm_next    = 1'b0;
    p2_mm_next    = 1'b0;
    invalid_next  = 1'b0;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (verifica_status) begin
          state_next    = SCAN;
          line_cnt_next = 4'd0;
          p1_found_next = 1'b0;
          p2_found_next = 1'b0;
          invalid_next  = sel_valid;
        end else if (sel_valid) begin
          if (move_ok) begin
            for (int i = 0; i < 9; i++) begin
              if (sel_cell == 4'(i)) board_next[2*i +: 2] = turno_p1 ? 2'b01 : 2'b10;
            end
            p1_mm_next = turno_p1;
            p2_mm_next = turno_p2;
          end else begin
            invalid_next = 1'b1;
          end
        end
      end
      SCAN: begin
        invalid_next = sel_valid;
        if (line_cnt_reg < 4'd8) begin
          if (line_p1[line_cnt_reg[2:0]]) p1_found_next = 1'b1;
          if (line_p2[line_cnt_reg[2:0]]) p2_found_next = 1'b1;
          line_cnt_next = line_cnt_reg + 4'd1;
        end else begin
          done_next     = 1'b1;
          line_cnt_next = 4'd0;
          if (p1_found_reg) begin
            result_next = 6'b100_010;
            state_next  = OVER;
          end else if (p2_found_reg) begin
            result_next = 6'b010_100;
            state_next  = OVER;
          end else if (&cell_occ[8:0]) begin
            result_next = 6'b001_001;
            state_next  = OVER;
          end else begin
            state_next = IDLE;
          end
        end
      end
      OVER: begin
        invalid_next = sel_valid;
        done_next    = verifica_status;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      line_cnt_reg <= 4'd0;
      p1_found_reg <= 1'b0;
      p2_found_reg <= 1'b0;
      board_reg    <= '0;
      result_reg   <= '0;
      p1_mm_reg    <= 1'b0;
      p2_mm_reg    <= 1'b0;
      invalid_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      line_cnt_reg <= line_cnt_next;
      p1_found_reg <= p1_found_next;
      p2_found_reg <= p2_found_next;
      board_reg    <= board_next;
      result_reg   <= result_next;
      p1_mm_reg    <= p1_mm_next;
      p2_mm_reg    <= p2_mm_next;
      invalid_reg  <= invalid_next;
      done_reg     <= done_next;
    end
  end

  assign board        = board_reg;
  assign p1_mm        = p1_mm_reg;
  assign p2_mm        = p2_mm_reg;
  assign invalid_move = invalid_reg;
  assign check_done   = done_reg;
  assign p1_win       = result_reg[5];
  assign p1_loss      = result_reg[4];
  assign p1_tie       = result_reg[3];
  assign p2_win       = result_reg[2];
  assign p2_loss      = result_reg[1];
  assign p2_tie       = result_reg[0];

endmodule

// File: tb/tb_gato_board.sv
// Directed bench for gato_board: moves, rejections, win/loss/tie verdicts,
// scan latency and reset during a scan.
module tb_gato_board;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        turno_p1 = 1'b0;
  logic        turno_p2 = 1'b0;
  logic        verifica_status = 1'b0;
  logic        sel_valid = 1'b0;
  logic [3:0]  sel_cell = 4'd0;
  logic        p1_mm, p2_mm, invalid_move, check_done;
  logic [17:0] board;
  logic        p1_win, p1_loss, p1_tie, p2_win, p2_loss, p2_tie;

  int n_cmp = 0;
  int n_bad = 0;

  gato_board dut (
    .clk(clk), .reset(reset), .turno_p1(turno_p1), .turno_p2(turno_p2),
    .verifica_status(verifica_status), .sel_valid(sel_valid), .sel_cell(sel_cell),
    .p1_mm(p1_mm), .p2_mm(p2_mm), .invalid_move(invalid_move), .board(board),
    .check_done(check_done), .p1_win(p1_win), .p1_loss(p1_loss), .p1_tie(p1_tie),
    .p2_win(p2_win), .p2_loss(p2_loss), .p2_tie(p2_tie)
  );

  always #5 clk = ~clk;

  wire [5:0] flags = {p1_win, p1_loss, p1_tie, p2_win, p2_loss, p2_tie};
  wire [2:0] mmv   = {p1_mm, p2_mm, invalid_move};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] bd(input logic [8:0] m1, input logic [8:0] m2);
    logic [17:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      if (m1[i]) r[2*i +: 2] = 2'b01;
      if (m2[i]) r[2*i +: 2] = 2'b10;
    end
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic sel(input logic t1, input logic t2, input logic [3:0] c);
    turno_p1 = t1; turno_p2 = t2; sel_cell = c; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0; turno_p1 = 1'b0; turno_p2 = 1'b0;
  endtask

  // Legal move expected to be accepted.
  task automatic play(input logic p2, input logic [3:0] c);
    sel(!p2, p2, c);
    check_eq($sformatf("move p%0d@%0d", p2 ? 2 : 1, c), 32'(mmv), p2 ? 32'b010 : 32'b100);
  endtask

  // Pulse verifica_status in IDLE and measure edges until check_done.
  task automatic run_check(output int lat);
    verifica_status = 1'b1;
    tick();
    verifica_status = 1'b0;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (check_done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int dones;

    // 1: reset state and first accepted move
    do_reset();
    check_eq("rst board", 32'(board), 32'h0);
    check_eq("rst flags", 32'(flags), 32'h0);
    check_eq("rst pulses", 32'({mmv, check_done}), 32'h0);
    sel(1'b1, 1'b0, 4'd4);
    check_eq("t1 pulses", 32'(mmv), 32'b100);
    check_eq("t1 board", 32'(board), 32'h00100);
    tick();
    check_eq("t1 mm drop", 32'(mmv), 32'b000);

    // 2: rejections
    sel(1'b0, 1'b1, 4'd4);
    check_eq("t2 occupied", 32'(mmv), 32'b001);
    sel(1'b0, 1'b1, 4'd9);
    check_eq("t2 cell9", 32'(mmv), 32'b001);
    sel(1'b1, 1'b1, 4'd0);
    check_eq("t2 both turns", 32'(mmv), 32'b001);
    sel(1'b0, 1'b0, 4'd0);
    check_eq("t2 no turn", 32'(mmv), 32'b001);
    check_eq("t2 board", 32'(board), 32'h00100);

    // 3: P1 wins on the top row
    do_reset();
    play(0, 0); play(1, 3); play(0, 1); play(1, 4); play(0, 2);
    check_eq("t3 board", 32'(board), 32'(bd(9'b000000111, 9'b000011000)));
    run_check(lat);
    check_eq("t3 latency", 32'(lat), 32'd9);
    check_eq("t3 flags", 32'(flags), 32'b100010);
    tick();
    check_eq("t3 done drop", 32'(check_done), 32'h0);
    sel(1'b0, 1'b1, 4'd8);
    check_eq("t3 over sel", 32'(mmv), 32'b001);
    verifica_status = 1'b1;
    tick();
    verifica_status = 1'b0;
    check_eq("t3 over done", 32'(check_done), 32'h1);
    check_eq("t3 over flags", 32'(flags), 32'b100010);
    check_eq("t3 over board", 32'(board), 32'(bd(9'b000000111, 9'b000011000)));

    // 4: P2 wins on the anti-diagonal
    do_reset();
    play(0, 0); play(1, 2); play(0, 1); play(1, 4); play(0, 8); play(1, 6);
    run_check(lat);
    check_eq("t4 latency", 32'(lat), 32'd9);
    check_eq("t4 flags", 32'(flags), 32'b010100);

    // 5a: eight cells, no line -> back to IDLE; 5b: fill last cell -> tie
    do_reset();
    play(0, 0); play(1, 1); play(0, 2); play(1, 4); play(0, 3); play(1, 5);
    play(0, 7); play(1, 6);
    run_check(lat);
    check_eq("t5 partial lat", 32'(lat), 32'd9);
    check_eq("t5 partial flags", 32'(flags), 32'h0);
    play(0, 8);
    check_eq("t5 full board", 32'(board), 32'(bd(9'b110001101, 9'b001110010)));
    run_check(lat);
    check_eq("t5 tie lat", 32'(lat), 32'd9);
    check_eq("t5 tie flags", 32'(flags), 32'b001001);

    // 6a: reset at the 4th scan cycle aborts the scan
    do_reset();
    play(0, 0); play(1, 3); play(0, 1); play(1, 4); play(0, 2);
    verifica_status = 1'b1;
    tick();
    verifica_status = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dones = int'(check_done);
    for (int n = 0; n < 12; n++) begin
      tick();
      dones += int'(check_done);
    end
    check_eq("t6 no done", 32'(dones), 32'd0);
    check_eq("t6 board", 32'(board), 32'h0);
    check_eq("t6 flags", 32'(flags), 32'h0);

    // 6b: verifica and sel_valid together -> selection rejected, scan runs
    play(0, 0);
    verifica_status = 1'b1; turno_p2 = 1'b1; sel_cell = 4'd5; sel_valid = 1'b1;
    tick();
    verifica_status = 1'b0; turno_p2 = 1'b0; sel_valid = 1'b0;
    check_eq("t6 both pulses", 32'(mmv), 32'b001);
    check_eq("t6 both board", 32'(board), 32'(bd(9'b000000001, 9'b0)));
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (check_done) begin
        lat = n;
        break;
      end
    end
    check_eq("t6 scan lat", 32'(lat), 32'd9);
    check_eq("t6 scan flags", 32'(flags), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gato_board.md
Name: gato_board

Overview:
Board-keeping and referee stage for the 3x3 tic-tac-toe (gato) game, located directly downstream of Gato_FSM. It consumes the FSM's turn indications (turno_p1, turno_p2) and its check request (verifica_status). It produces the move-made pulses (p1_mm, p2_mm) and the result flags (p1/p2 win/loss/tie) that drive the FSM's transitions. It owns the board register, validates cell selections, and evaluates the eight winning lines sequentially, one line per clock.

Parameters:
None. The board is fixed at 3x3, with 9 cells and 8 lines.

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  synchronous, active-high; clears the whole block
turno_p1  in  1  level; it is P1's turn (from Gato_FSM)
turno_p2  in  1  level; it is P2's turn (from Gato_FSM)
verifica_status  in  1  level/pulse; request board evaluation (from Gato_FSM)
sel_valid  in  1  one-cycle pulse; a cell selection is presented
sel_cell  in  4  selected cell index, row-major 0..8
p1_mm  out  1  one-cycle pulse; P1 move accepted and written
p2_mm  out  1  one-cycle pulse; P2 move accepted and written
invalid_move  out  1  one-cycle pulse; selection rejected
board  out  18  cell i occupies bits [2i+1:2i]; 00 empty, 01 P1, 10 P2; 11 never produced
check_done  out  1  one-cycle pulse; evaluation finished
p1_win, p1_loss, p1_tie  out  1 each  sticky result flags
p2_win, p2_loss, p2_tie  out  1 each  sticky result flags

Behaviour:
- Clocking and reset:
  - One clock. reset is synchronous and active-high.
  - On reset: board=0, every output=0, state=IDLE, line counter=0, internal found flags=0.
  - Reset overrides all other inputs in the same cycle.
- States: IDLE, SCAN, OVER.
- IDLE, move handling (sel_valid=1 and verifica_status=0 at edge k):
  - Accept the move only if all of the following hold: exactly one of turno_p1/turno_p2 is 1; sel_cell<=8; the selected cell is 00.
  - On accept, at edge k: write 01 (P1) or 10 (P2) into the cell, and register p1_mm or p2_mm=1 for exactly one cycle (visible k..k+1).
  - Otherwise: invalid_move=1 for one cycle and the board is unchanged.
  - Both turno inputs high, or both low, means reject.
- IDLE, check request (verifica_status=1 at edge k):
  - Go to SCAN and clear the found flags.
  - If sel_valid is also 1 in that cycle, verifica_status wins and the selection is rejected with invalid_move.
- SCAN, line evaluation:
  - Line order, one line per edge k+1..k+8:
    - rows {0,1,2}, {3,4,5}, {6,7,8}
    - cols {0,3,6}, {1,4,7}, {2,5,8}
    - diags {0,4,8}, {2,4,6}
  - A line whose three cells all equal 01 sets p1_found. A line whose three cells all equal 10 sets p2_found.
- SCAN, completion at edge k+9:
  - check_done=1 for one cycle.
  - If p1_found: p1_win=1, p2_loss=1, go to OVER. P1 takes priority if both players are found; this is unreachable in legal play.
  - Else if p2_found: p2_win=1, p1_loss=1, go to OVER.
  - Else if all 9 cells are non-zero: p1_tie=p2_tie=1, go to OVER.
  - Else: no flags set, return to IDLE.
- SCAN, other inputs:
  - sel_valid during SCAN: rejected with invalid_move, board unchanged.
  - verifica_status during SCAN: ignored; it does not restart the scan.
- OVER:
  - Result flags and board are held until reset.
  - sel_valid produces invalid_move.
  - verifica_status produces a check_done pulse on the next edge; the flags are unchanged.
- Output exclusivity:
  - p1_mm, p2_mm and invalid_move are mutually exclusive and never exceed one cycle per sel_valid.
  - At most one player's win flag is ever set.
- Reset mid-scan: the scan is aborted, check_done never pulses, and all outputs are 0 from the next cycle.
- sel_cell values 9..15 are always rejected, in any state.

Test Plan:
1. Reset, then turno_p1=1 with sel_valid pulse and sel_cell=4 -> p1_mm=1 for exactly 1 cycle; board=18'h00100 (bits[9:8]=01); p2_mm=0, invalid_move=0.
2. Cell 4 occupied, turno_p2=1, sel_cell=4 -> invalid_move pulse, no p2_mm, board unchanged. Repeat with sel_cell=9 -> invalid_move. Repeat with turno_p1=turno_p2=1 -> invalid_move.
3. P1 plays 0,1,2 and P2 plays 3,4, then verifica_status pulse -> check_done exactly 9 edges later, p1_win=p2_loss=1, other flags 0. A later sel_valid -> invalid_move. Further verifica_status -> check_done next edge, flags held.
4. P2 plays 2,4,6 and P1 plays 0,1,8, then verifica -> p2_win=p1_loss=1 after 9 cycles.
5. Full board without a line: P1 at 0,2,3,7,8 and P2 at 1,4,5,6, then verifica -> p1_tie=p2_tie=1, no win/loss flags. Variant with an 8-cell board and no line -> check_done only, all flags 0, state back to IDLE (a new move is accepted).
6. Winning board, verifica, then reset at the 4th SCAN cycle -> check_done never asserts, board=0, all flags 0. verifica_status and sel_valid in the same IDLE cycle -> invalid_move, and the scan proceeds.
